// File: rtl/square_col_accum_if.sv
// Stream bundle between the partial-product source, the column accumulator and the limb consumer.
// The master side drives products and accepts limbs. The slave side is the accumulator.
interface square_col_accum_if #(
  parameter int NUM_LIMBS = 2,
  parameter int LIMB_W    = 42
);
  localparam int NCOL = 2 * NUM_LIMBS;
  localparam int CW   = $clog2(NCOL);

  logic                  in_valid;
  logic                  in_ready;
  logic [2*LIMB_W+1:0]   in_data;
  logic [CW-1:0]         in_col;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [LIMB_W-1:0]     out_limb;
  logic [CW-1:0]         out_idx;
  logic                  out_last;
  logic                  busy;
  logic                  err;

  modport master (
    output in_valid, in_data, in_col, in_last, out_ready,
    input  in_ready, out_valid, out_limb, out_idx, out_last, busy, err
  );

  modport slave (
    input  in_valid, in_data, in_col, in_last, out_ready,
    output in_ready, out_valid, out_limb, out_idx, out_last, busy, err
  );
endinterface

// File: rtl/square_col_accum.sv
// Sums column-tagged partial products into wide column registers.
// It then carry-normalises the columns and emits the square one limb per cycle, LS limb first.
module square_col_accum #(
  parameter int NUM_LIMBS = 2,
  parameter int LIMB_W    = 42,
  parameter int ACC_W     = 52
) (
  input logic                clk,
  input logic                rst_n,
  square_col_accum_if.slave  sq_io
);
  localparam int NCOL = 2 * NUM_LIMBS;
  localparam int CW   = $clog2(NCOL);
  localparam int HI_W = LIMB_W + 2;
  localparam int CY_W = ACC_W - LIMB_W + 1;

  typedef enum logic {ST_ACCUM, ST_NORM} state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q [NCOL];
  logic [CY_W-1:0]     carry_q;
  logic [CW-1:0]       j_q;
  logic                norm_go_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                busy_q;
  logic                err_q;
  logic [LIMB_W-1:0]   out_limb_q;
  logic [CW-1:0]       out_idx_q;

  logic                in_fire;
  logic                col_ok;
  logic                top_drop_err;
  logic [LIMB_W-1:0]   lo_part;
  logic [HI_W-1:0]     hi_part;
  logic [ACC_W:0]      col_sum [NCOL];
  logic [NCOL-1:0]     col_ovf;
  logic [ACC_W:0]      norm_sum;

  assign in_fire      = sq_io.in_valid & in_ready_q;
  assign lo_part      = sq_io.in_data[LIMB_W-1:0];
  assign hi_part      = sq_io.in_data[2*LIMB_W+1:LIMB_W];
  assign col_ok       = 32'(sq_io.in_col) < NCOL;
  // The upper half of a product landing in the top column has nowhere to go.
  assign top_drop_err = col_ok && (32'(sq_io.in_col) == NCOL - 1) && (hi_part != '0);

  for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
    logic [ACC_W-1:0] addend;
    always_comb begin
      addend = '0;
      if (32'(sq_io.in_col) == gi)
        addend = ACC_W'(lo_part);
      else if (gi > 0 && 32'(sq_io.in_col) == gi - 1)
        addend = ACC_W'(hi_part);
    end
    assign col_sum[gi] = {1'b0, acc_q[gi]} + {1'b0, addend};
    assign col_ovf[gi] = col_sum[gi][ACC_W];
  end

  assign norm_sum = {1'b0, acc_q[j_q]} + (ACC_W + 1)'(carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      for (int k = 0; k < NCOL; k++) acc_q[k] <= '0;
      carry_q     <= '0;
      j_q         <= '0;
      norm_go_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      out_limb_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_fire) begin
            if (col_ok) begin
              for (int k = 0; k < NCOL; k++) acc_q[k] <= col_sum[k][ACC_W-1:0];
              if ((|col_ovf) || top_drop_err) err_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            if (sq_io.in_last) begin
              state_q    <= ST_NORM;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              j_q        <= '0;
              carry_q    <= '0;
              norm_go_q  <= 1'b0;
            end
          end
        end
        ST_NORM: begin
          // One settle cycle places the first limb two cycles after the final product.
          if (!norm_go_q) begin
            norm_go_q <= 1'b1;
          end else if (!out_valid_q || sq_io.out_ready) begin
            if (out_valid_q && out_last_q) begin
              if (carry_q != '0) err_q <= 1'b1;
              for (int k = 0; k < NCOL; k++) acc_q[k] <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              carry_q     <= '0;
              j_q         <= '0;
              norm_go_q   <= 1'b0;
              state_q     <= ST_ACCUM;
            end else begin
              out_limb_q  <= norm_sum[LIMB_W-1:0];
              out_idx_q   <= j_q;
              out_last_q  <= (32'(j_q) == NCOL - 1);
              out_valid_q <= 1'b1;
              carry_q     <= norm_sum[ACC_W:LIMB_W];
              j_q         <= j_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign sq_io.in_ready  = in_ready_q;
  assign sq_io.out_valid = out_valid_q;
  assign sq_io.out_limb  = out_limb_q;
  assign sq_io.out_idx   = out_idx_q;
  assign sq_io.out_last  = out_last_q;
  assign sq_io.busy      = busy_q;
  assign sq_io.err       = err_q;
endmodule

// File: tb/tb_square_col_accum.sv
// Randomised scoreboard bench for square_col_accum.
// Expected limbs come from whole-number squares; a monitor checks every limb handshake.
module tb_square_col_accum;
  localparam int NL   = 2;
  localparam int W    = 42;
  localparam int NCOL = 2 * NL;
  localparam int CW   = $clog2(NCOL);
  localparam int RW   = NCOL * W;

  typedef struct {
    logic [W-1:0]  limb;
    logic [CW-1:0] idx;
    logic          last;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  logic err_exp;
  int   ready_mode;   // 0 always ready, 1 random, 2 manual
  logic ready_manual;

  square_col_accum_if #(.NUM_LIMBS(NL), .LIMB_W(W)) bus ();

  square_col_accum #(.NUM_LIMBS(NL), .LIMB_W(W), .ACC_W(52)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sq_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, required summary before limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_square(input logic [RW-1:0] v);
    for (int k = 0; k < NCOL; k++) begin
      exp_t e;
      e.limb = v[k*W +: W];
      e.idx  = CW'(k);
      e.last = (k == NCOL - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [2*W+1:0] data, input int col, input logic last);
    int gap;
    bit done;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_col   = CW'(col);
    bus.in_last  = last;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) check("in_handshake_timeout", 64'(done), 64'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) tick();
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 50 && !bus.out_valid; i++) tick();
    check("out_valid_arrives", 64'(bus.out_valid), 64'd1);
  endtask

  // Lets exactly one limb handshake through while out_ready is under manual control.
  task automatic pulse_ready();
    ready_manual = 1'b1;
    tick();
    ready_manual = 1'b0;
    tick();
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = ready_manual;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_limb", 64'(bus.out_idx), 64'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("limb_value", 64'(bus.out_limb), 64'(e.limb));
          check("limb_idx",   64'(bus.out_idx),  64'(e.idx));
          check("limb_last",  64'(bus.out_last), 64'(e.last));
          check("busy_during_out", 64'(bus.busy), 64'd1);
          check("err_during_out",  64'(bus.err),  64'(err_exp));
          $display("[TB] limb idx=%0d value=%0h last=%0d", bus.out_idx, bus.out_limb, bus.out_last);
        end
      end
    end
  end

  initial begin
    logic [RW-1:0]  v;
    logic [W-1:0]   x0;
    logic [W-1:0]   x1;
    logic [2*W-1:0] x;
    logic [2*W+1:0] p;
    logic [W-1:0]   hold;

    n_tests      = 0;
    n_fail       = 0;
    err_exp      = 1'b0;
    ready_mode   = 0;
    ready_manual = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_col   = '0;
    bus.in_last  = 1'b0;
    repeat (3) tick();
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_limb",  64'(bus.out_limb),  64'd0);
    check("rst_out_idx",   64'(bus.out_idx),   64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_err",       64'(bus.err),       64'd0);
    rst_n = 1'b1;
    tick();

    // Single product square, including the two-cycle first-limb latency.
    expect_square(RW'(3));
    send(86'd3, 0, 1'b1);
    check("t1_in_ready_low", 64'(bus.in_ready),  64'd0);
    check("t1_busy_high",    64'(bus.busy),      64'd1);
    check("t1_valid_cyc1",   64'(bus.out_valid), 64'd0);
    tick();
    check("t1_valid_cyc2",   64'(bus.out_valid), 64'd0);
    tick();
    check("t1_valid_cyc3",   64'(bus.out_valid), 64'd1);
    drain();
    tick();
    check("t1_in_ready_back", 64'(bus.in_ready), 64'd1);
    check("t1_busy_low",      64'(bus.busy),     64'd0);
    check("t1_err",           64'(bus.err),      64'd0);

    // Carry ripple from column 0 into column 1.
    p = '0;
    p[W-1:0] = '1;
    v = RW'(p) + RW'(p);
    expect_square(v);
    send(p, 0, 1'b0);
    send(p, 0, 1'b1);
    drain();

    // Backpressure while idx 1 is presented.
    ready_mode   = 2;
    ready_manual = 1'b0;
    tick();
    v = RW'(86'h123456789ABCDEF) + (RW'(77) << W);
    expect_square(v);
    send(86'h123456789ABCDEF, 0, 1'b0);
    send(86'd77, 1, 1'b1);
    wait_out_valid();
    check("t3_first_idx", 64'(bus.out_idx), 64'd0);
    pulse_ready();
    hold = v[W +: W];
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t3_hold_idx",   64'(bus.out_idx),   64'd1);
      check("t3_hold_limb",  64'(bus.out_limb),  64'(hold));
      check("t3_in_ready",   64'(bus.in_ready),  64'd0);
    end
    ready_manual = 1'b1;
    tick();
    check("t3_b2b_idx2", 64'(bus.out_idx), 64'd2);
    tick();
    check("t3_b2b_idx3", 64'(bus.out_idx), 64'd3);
    check("t3_b2b_last", 64'(bus.out_last), 64'd1);
    ready_mode = 0;
    drain();

    // Random squares with input gaps and random backpressure.
    ready_mode = 1;
    for (int n = 0; n < 2000; n++) begin
      x0 = W'({$urandom, $urandom});
      x1 = W'({$urandom, $urandom});
      if ($urandom_range(0, 15) == 0) x0 = '1;
      if ($urandom_range(0, 15) == 0) x1 = '1;
      x = {x1, x0};
      expect_square(RW'(x) * RW'(x));
      send((2*W+2)'(x0) * (2*W+2)'(x0), 0, 1'b0);
      send(((2*W+2)'(x0) * (2*W+2)'(x1)) << 1, 1, 1'b0);
      send((2*W+2)'(x1) * (2*W+2)'(x1), 2, 1'b1);
    end
    drain();
    ready_mode = 0;
    check("t5_err_clean", 64'(bus.err), 64'd0);

    // Nonzero upper part in the top column raises a sticky err.
    expect_square('0);
    send(86'd1 << W, 3, 1'b1);
    err_exp = 1'b1;
    drain();
    tick();
    check("t4_err_set", 64'(bus.err), 64'd1);
    expect_square(RW'(3));
    send(86'd3, 0, 1'b1);
    drain();
    tick();
    check("t4_err_sticky", 64'(bus.err), 64'd1);

    // Reset while idx 2 is presented aborts the result.
    ready_mode   = 2;
    ready_manual = 1'b0;
    tick();
    expect_square(RW'(86'h3FF_FFFF_FFFF_1234));
    send(86'h3FF_FFFF_FFFF_1234, 0, 1'b1);
    wait_out_valid();
    pulse_ready();
    pulse_ready();
    check("t6_idx2_shown", 64'(bus.out_idx), 64'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_busy",      64'(bus.busy),      64'd0);
    check("t6_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("t6_rst_err",       64'(bus.err),       64'd0);
    sb.delete();
    err_exp = 1'b0;
    tick();
    tick();
    rst_n      = 1'b1;
    ready_mode = 0;
    tick();
    expect_square(RW'(86'd12345) + (RW'(86'd99) << (2 * W)));
    send(86'd12345, 0, 1'b0);
    send(86'd99, 2, 1'b1);
    drain();
    tick();
    check("t6_after_err", 64'(bus.err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
